// File: rtl/bci_fe_pkg.sv
// bci_fe_pkg: shared sample/epoch defaults and the framer state encoding
package bci_fe_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int EPOCH_LENGTH = 256;
    typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} framer_state_t;
endpackage

// File: rtl/epoch_framer_if.sv
// epoch_framer_if: sample stream in, windowing-stage burst out
// i_valid/i_sample: accepted input sample, no backpressure
// o_en/o_sample: windowing-stage en/signal_in; o_busy: burst in progress; o_overrun: dropped trigger pulse
interface epoch_framer_if #(
    parameter int DATA_WIDTH = bci_fe_pkg::DATA_WIDTH
);
    logic i_valid;
    logic signed [DATA_WIDTH-1:0] i_sample;
    logic o_en;
    logic signed [DATA_WIDTH-1:0] o_sample;
    logic o_busy;
    logic o_overrun;
    modport master (output i_valid, i_sample, input o_en, o_sample, o_busy, o_overrun);
    modport slave (input i_valid, i_sample, output o_en, o_sample, o_busy, o_overrun);
endinterface

// File: rtl/epoch_sample_ram.sv
// epoch_sample_ram: simple dual-port sample buffer with a 1-cycle registered read
// clk; i_we/i_waddr/i_wdata: write port; i_raddr/o_rdata: read port (read-old on address collision)
module epoch_sample_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/epoch_framer.sv
// epoch_framer: buffers samples and streams overlapping EPOCH_LENGTH+1 cycle bursts to the windowing stage
// clk, rst (async, active high); bus: epoch_framer_if slave (i_valid/i_sample in, o_en/o_sample/o_busy/o_overrun out)
module epoch_framer #(
    parameter int EPOCH_LENGTH = bci_fe_pkg::EPOCH_LENGTH,
    parameter int HOP_LENGTH = 128,
    parameter int DATA_WIDTH = bci_fe_pkg::DATA_WIDTH
) (
    input logic clk,
    input logic rst,
    epoch_framer_if.slave bus
);
    import bci_fe_pkg::*;
    localparam int BUF_DEPTH = 2 * EPOCH_LENGTH;
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int FW = $clog2(EPOCH_LENGTH + 1);
    localparam int HW = HOP_LENGTH > 1 ? $clog2(HOP_LENGTH) : 1;
    localparam int CW = $clog2(EPOCH_LENGTH) + 1;

    framer_state_t r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_slot_addr;
    logic r_slot_full;
    logic [FW-1:0] r_fill;
    logic [HW-1:0] r_hop;
    logic [CW-1:0] r_cnt;
    logic r_en;
    logic signed [DATA_WIDTH-1:0] r_sample;
    logic r_busy;
    logic r_overrun;
    logic signed [DATA_WIDTH-1:0] w_rdata;
    logic w_saturated;
    logic w_trig;
    logic w_launch;
    logic w_drop;
    logic [AW-1:0] w_start;
    logic [AW-1:0] w_rd_addr;

    assign w_saturated = r_fill == FW'(EPOCH_LENGTH);
    assign w_trig = bus.i_valid && (r_fill == FW'(EPOCH_LENGTH - 1) || (w_saturated && r_hop == HW'(HOP_LENGTH - 1)));
    assign w_start = r_wr_ptr + AW'(1) - AW'(EPOCH_LENGTH);
    // the slot is consumed wherever the FSM can enter PRIME
    assign w_launch = r_slot_full && (r_state == IDLE || r_state == FLUSH);
    assign w_drop = w_trig && r_slot_full && !w_launch;
    // the first word is fetched on the edge into PRIME so it is ready when o_en rises
    assign w_rd_addr = w_launch ? r_slot_addr : r_rd_ptr;

    epoch_sample_ram #(.DEPTH(BUF_DEPTH), .WIDTH(DATA_WIDTH)) u_ram (
        .clk(clk),
        .i_we(bus.i_valid),
        .i_waddr(r_wr_ptr),
        .i_wdata(bus.i_sample),
        .i_raddr(w_rd_addr),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_fill <= '0;
            r_hop <= '0;
            r_slot_full <= 1'b0;
            r_slot_addr <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (bus.i_valid) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (!w_saturated) r_fill <= r_fill + FW'(1);
                else r_hop <= r_hop == HW'(HOP_LENGTH - 1) ? '0 : r_hop + HW'(1);
            end
            if (w_trig && !w_drop) r_slot_addr <= w_start;
            r_slot_full <= (w_trig && !w_drop) || (r_slot_full && !w_launch);
            r_overrun <= w_drop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rd_ptr <= '0;
            r_cnt <= '0;
            r_en <= 1'b0;
            r_sample <= '0;
            r_busy <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_addr + AW'(1);
            case (r_state)
                PRIME: begin
                    r_state <= STREAM;
                    r_en <= 1'b1;
                    r_sample <= w_rdata;
                    r_cnt <= CW'(1);
                end
                STREAM: begin
                    r_state <= r_cnt == CW'(EPOCH_LENGTH) ? FLUSH : STREAM;
                    r_sample <= r_cnt == CW'(EPOCH_LENGTH) ? '0 : w_rdata;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: begin
                    r_state <= w_launch ? PRIME : IDLE;
                    r_en <= 1'b0;
                    r_busy <= w_launch;
                end
            endcase
        end
    end

    assign bus.o_en = r_en;
    assign bus.o_sample = r_sample;
    assign bus.o_busy = r_busy;
    assign bus.o_overrun = r_overrun;
endmodule

// File: tb/tb_epoch_framer.sv
// tb_epoch_framer: scoreboard bench for epoch_framer with directed sample streams
module tb_epoch_framer;
    localparam int EL = 256;
    logic clk = 1'b0;
    logic rst;
    logic signed [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int run = 0;
    int gap = 0;
    int last_gap = 0;
    int ov_cnt = 0;

    always #5 clk = ~clk;

    epoch_framer_if #(.DATA_WIDTH(32)) bus ();
    epoch_framer #(.EPOCH_LENGTH(EL), .HOP_LENGTH(128), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int v, input int idle);
        bus.i_valid = 1'b1;
        bus.i_sample = v;
        step();
        bus.i_valid = 1'b0;
        repeat (idle) step();
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) exp_q.push_back(v);
        exp_q.push_back(0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_burst(input string nm);
        bit seen;
        int i;
        seen = 1'b0;
        for (i = 0; i < 2000; i++) begin
            if (bus.o_busy) seen = 1'b1;
            else if (seen) break;
            step();
        end
        chk({nm, "_done"}, longint'(i < 2000), 1);
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
            gap = 0;
        end else begin
            if (bus.o_overrun) ov_cnt++;
            if (bus.o_en) begin
                if (run == 0) last_gap = gap;
                run++;
                gap = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_en: o_sample=%0d with nothing expected", bus.o_sample);
                end else chk("o_sample", bus.o_sample, exp_q.pop_front());
            end else begin
                if (run > 0) chk("burst_len", run, EL + 1);
                run = 0;
                gap++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_sample = '0;
        for (int i = 0; i < 6; i++) begin
            bus.i_valid = ~bus.i_valid;
            bus.i_sample = i + 7;
            step();
            chk("rst_outputs", {bus.o_en, bus.o_busy, bus.o_overrun, bus.o_sample}, 0);
        end
        bus.i_valid = 1'b0;
        rst = 1'b0;
        step();

        for (int i = 1; i < EL; i++) put(i, 3);
        put(EL, 0);
        push_range(1, EL);
        chk("lat_t0_en", bus.o_en, 0);
        step();
        chk("lat_t1_en", bus.o_en, 0);
        chk("lat_t1_busy", bus.o_busy, 1);
        step();
        chk("lat_t2_en", bus.o_en, 1);
        chk("lat_t2_sample", bus.o_sample, 1);
        wait_burst("epoch1");

        for (int i = 257; i < 384; i++) put(i, 3);
        put(384, 0);
        push_range(129, 384);
        wait_burst("epoch2");
        chk("epoch2_overrun", ov_cnt, 0);

        do_reset();
        ov_cnt = 0;
        for (int i = 1; i <= 600; i++) begin
            put(i, 0);
            if (i == 256) push_range(1, 256);
            if (i == 384) push_range(129, 384);
        end
        wait_burst("b2b");
        repeat (300) step();
        chk("b2b_overrun", ov_cnt, 1);
        chk("b2b_gap", last_gap, 1);
        chk("b2b_no_third", exp_q.size(), 0);

        do_reset();
        for (int i = 1; i <= EL; i++) put(-i, 0);
        for (int i = 1; i <= EL; i++) exp_q.push_back(-i);
        exp_q.push_back(0);
        wait_burst("neg");

        do_reset();
        for (int i = 1; i <= EL; i++) put(1000 + i, 0);
        for (int v = 1001; v <= 1099; v++) exp_q.push_back(v);
        n = 0;
        for (int i = 0; i < 400 && n < 100; i++) begin
            if (bus.o_en) n++;
            if (n < 100) step();
        end
        chk("mid_reached", n, 100);
        rst = 1'b1;
        #1;
        chk("mid_rst_en", bus.o_en, 0);
        chk("mid_rst_busy", bus.o_busy, 0);
        chk("mid_rst_sample", bus.o_sample, 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_drained", exp_q.size(), 0);
        for (int i = 1; i < EL; i++) put(2000 + i, 0);
        repeat (5) step();
        chk("refill_busy", bus.o_busy, 0);
        chk("refill_en", bus.o_en, 0);
        put(2000 + EL, 0);
        push_range(2001, 2000 + EL);
        wait_burst("refill");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
